// File: rtl/seq_store.sv
// seq_store: in-order result buffer between the sequence FSM and the display.
// Accepted FSM words are stored in order. Errors and overflows are latched in
// sticky flags. A step-through read port drives the seven-segment NUMBER input.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   clear    - synchronous clear pulse, same effect as reset
//   wr_valid - one-cycle result strobe from the FSM
//   wr_err   - FSM error flag, qualified by wr_valid
//   wr_data  - FSM result word, qualified by wr_valid
//   rd_next  - one-cycle advance pulse for the read pointer
//   rd_data  - registered word at the current read pointer
//   rd_index - current read pointer
//   count    - number of stored words, 0..DEPTH
//   full     - count == DEPTH (combinational)
//   empty    - count == 0 (combinational)
//   err_out  - sticky flags: [0] FSM error reported, [1] overflow
module seq_store #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic             wr_err,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_next,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W-1:0] rd_index,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [1:0]       err_out
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_index;
    logic [PTR_W-1:0] r_count;
    logic [1:0]       r_err;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_full;
    logic             w_empty;
    logic             w_do_write;
    logic             w_rd_last;

    assign w_full     = (r_count == PTR_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_do_write = wr_valid && !wr_err && !w_full;
    // Wrap is decided on the count seen before any same-cycle write.
    assign w_rd_last  = (r_rd_index == (r_count - PTR_W'(1)));

    // Storage, pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_index <= '0;
            r_count    <= '0;
            r_err      <= 2'b00;
        end else begin
            if (wr_valid) begin
                if (wr_err) begin
                    r_err[0] <= 1'b1;
                end else if (w_full) begin
                    r_err[1] <= 1'b1;
                end
            end
            if (w_do_write) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_count         <= r_count + PTR_W'(1);
            end
            if (rd_next && !w_empty) begin
                r_rd_index <= w_rd_last ? '0 : r_rd_index + PTR_W'(1);
            end
        end
    end

    // Display word follows memory one cycle behind pointer and writes; a clear
    // therefore shows zero one cycle after the clear edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[r_rd_index];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_index = r_rd_index;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign err_out  = r_err;

endmodule
